// File: rtl/ddebounce_pkg.sv
// ddebounce_pkg: shared state encoding and sizing helper for the debouncer
package ddebounce_pkg;
  typedef enum logic [1:0] {LO, LO2HI, HI, HI2LO} state_t;
  function automatic int cnt_w(input int hold);
    return $clog2(hold) + 1;
  endfunction
endpackage

// File: rtl/dtick.sv
// dtick: free-running prescaler emitting one tick every DIV clk cycles
module dtick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic nreset,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] c;
  assign tick = c == CW'(DIV - 1);
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) c <= '0;
    else c <= tick ? '0 : c + 1'b1;
endmodule

// File: rtl/ddebounce.sv
// ddebounce: tick-qualified debounce with rise/fall pulses and saturating glitch count
module ddebounce
  import ddebounce_pkg::*;
#(
  parameter int HOLD = 4,
  parameter int DIV  = 1,
  parameter int GW   = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          din,
  input  logic          clr,
  output logic          dout,
  output logic          rise,
  output logic          fall,
  output logic [GW-1:0] glitch_cnt
);
  localparam int CW = cnt_w(HOLD);
  state_t st;
  logic [CW-1:0] cnt;
  logic tick, glitch, done;
  dtick #(.DIV(DIV)) u_tick (.clk(clk), .nreset(nreset), .tick(tick));
  always_comb begin
    glitch = (st == LO2HI && !din) || (st == HI2LO && din);
    done   = tick && cnt == CW'(HOLD - 1);
  end
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      st   <= LO;
      cnt  <= '0;
      dout <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (st)
        LO: if (din) begin
          st  <= LO2HI;
          cnt <= '0;
        end
        HI: if (!din) begin
          st  <= HI2LO;
          cnt <= '0;
        end
        LO2HI: if (!din) st <= LO;
        else if (done) begin
          st   <= HI;
          dout <= 1'b1;
          rise <= 1'b1;
        end else if (tick) cnt <= cnt + 1'b1;
        HI2LO: if (din) st <= HI;
        else if (done) begin
          st   <= LO;
          dout <= 1'b0;
          fall <= 1'b1;
        end else if (tick) cnt <= cnt + 1'b1;
      endcase
    end
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) glitch_cnt <= '0;
    else glitch_cnt <= clr ? '0 : (glitch && !(&glitch_cnt)) ? glitch_cnt + 1'b1 : glitch_cnt;
endmodule

// File: tb/tb_ddebounce.sv
// tb_ddebounce: directed checks of debounce, prescale, saturation, reset and HOLD=1 corners
module tb_ddebounce;
  logic clk = 1'b0;
  logic nrst0, nrst1, nrst2, nrst3;
  logic din0, din1, din2, din3;
  logic clr0, clr1, clr2, clr3;
  logic dout0, dout1, dout2, dout3;
  logic rise0, rise1, rise2, rise3;
  logic fall0, fall1, fall2, fall3;
  logic [7:0] gc0, gc1, gc3;
  logic [1:0] gc2;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  ddebounce #(.HOLD(4), .DIV(1), .GW(8)) d0 (.clk(clk), .nreset(nrst0), .din(din0), .clr(clr0), .dout(dout0), .rise(rise0), .fall(fall0), .glitch_cnt(gc0));
  ddebounce #(.HOLD(3), .DIV(4), .GW(8)) d1 (.clk(clk), .nreset(nrst1), .din(din1), .clr(clr1), .dout(dout1), .rise(rise1), .fall(fall1), .glitch_cnt(gc1));
  ddebounce #(.HOLD(4), .DIV(1), .GW(2)) d2 (.clk(clk), .nreset(nrst2), .din(din2), .clr(clr2), .dout(dout2), .rise(rise2), .fall(fall2), .glitch_cnt(gc2));
  ddebounce #(.HOLD(1), .DIV(1), .GW(8)) d3 (.clk(clk), .nreset(nrst3), .din(din3), .clr(clr3), .dout(dout3), .rise(rise3), .fall(fall3), .glitch_cnt(gc3));
  task automatic edge_();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    {nrst0, nrst1, nrst2, nrst3} = 4'b0;
    {din0, din1, din2, din3} = 4'b0;
    {clr0, clr1, clr2, clr3} = 4'b0;
    #1;
    checks++;
    if ({dout0, rise0, fall0, gc0} !== 11'd0) begin
      errors++;
      $display("FAIL reset d0: dout=%b rise=%b fall=%b gc=%0d, want all 0", dout0, rise0, fall0, gc0);
    end
    checks++;
    if ({dout3, rise3, fall3, gc3} !== 11'd0) begin
      errors++;
      $display("FAIL reset d3: dout=%b rise=%b fall=%b gc=%0d, want all 0", dout3, rise3, fall3, gc3);
    end
    edge_();
    edge_();
    #2;
    {nrst0, nrst1, nrst2, nrst3} = 4'hf;
  endtask
  task automatic test_clean();
    din0 = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      edge_();
      checks++;
      if (dout0 !== (i >= 4) || rise0 !== (i == 4) || fall0 !== 1'b0) begin
        errors++;
        $display("FAIL clean_rise edge %0d: dout=%b rise=%b fall=%b, want dout=%b rise=%b fall=0", i, dout0, rise0, fall0, i >= 4, i == 4);
      end
    end
    repeat (3) edge_();
    din0 = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      edge_();
      checks++;
      if (dout0 !== (i < 4) || fall0 !== (i == 4) || rise0 !== 1'b0) begin
        errors++;
        $display("FAIL clean_fall edge %0d: dout=%b rise=%b fall=%b, want dout=%b rise=0 fall=%b", i, dout0, rise0, fall0, i < 4, i == 4);
      end
    end
    checks++;
    if (gc0 !== 8'd0) begin
      errors++;
      $display("FAIL clean_glitch: got %0d want 0", gc0);
    end
  endtask
  task automatic test_bounce();
    int pat[13] = '{1, 1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < 13; i++) begin
      din0 = pat[i][0];
      edge_();
      checks++;
      if (dout0 !== (i >= 10) || rise0 !== (i == 10)) begin
        errors++;
        $display("FAIL bounce edge %0d: dout=%b rise=%b, want dout=%b rise=%b", i, dout0, rise0, i >= 10, i == 10);
      end
    end
    checks++;
    if (gc0 !== 8'd2) begin
      errors++;
      $display("FAIL bounce_glitch: got %0d want 2", gc0);
    end
    din0 = 1'b0;
    repeat (6) edge_();
    checks++;
    if (dout0 !== 1'b0 || gc0 !== 8'd2) begin
      errors++;
      $display("FAIL bounce_release: dout=%b gc=%0d, want dout=0 gc=2", dout0, gc0);
    end
  endtask
  task automatic test_prescale();
    int lat = -1;
    din1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      edge_();
      if (dout1 === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat < 9 || lat > 12 || rise1 !== 1'b1) begin
      errors++;
      $display("FAIL prescale_latency: got %0d rise=%b, want 9..12 rise=1", lat, rise1);
    end
    din1 = 1'b0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      edge_();
      if (dout1 === 1'b0) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat < 9 || lat > 12 || fall1 !== 1'b1) begin
      errors++;
      $display("FAIL prescale_fall: got %0d fall=%b, want 9..12 fall=1", lat, fall1);
    end
    edge_();
    din1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      edge_();
      checks++;
      if (dout1 !== 1'b0 || rise1 !== 1'b0) begin
        errors++;
        $display("FAIL prescale_pulse edge %0d: dout=%b rise=%b, want 0 0", i, dout1, rise1);
      end
    end
    din1 = 1'b0;
    repeat (3) edge_();
    checks++;
    if (dout1 !== 1'b0 || gc1 !== 8'd1) begin
      errors++;
      $display("FAIL prescale_glitch: dout=%b gc=%0d, want dout=0 gc=1", dout1, gc1);
    end
  endtask
  task automatic test_saturation();
    for (int g = 1; g <= 5; g++) begin
      din2 = 1'b1;
      edge_();
      din2 = 1'b0;
      edge_();
      checks++;
      if (gc2 !== 2'(g < 3 ? g : 3)) begin
        errors++;
        $display("FAIL saturate glitch %0d: got %0d want %0d", g, gc2, g < 3 ? g : 3);
      end
    end
    din2 = 1'b1;
    edge_();
    din2 = 1'b0;
    clr2 = 1'b1;
    edge_();
    clr2 = 1'b0;
    checks++;
    if (gc2 !== 2'd0) begin
      errors++;
      $display("FAIL clr_wins: got %0d want 0", gc2);
    end
    din2 = 1'b1;
    edge_();
    din2 = 1'b0;
    edge_();
    checks++;
    if (gc2 !== 2'd1) begin
      errors++;
      $display("FAIL after_clr: got %0d want 1", gc2);
    end
  endtask
  task automatic test_reset_mid();
    din2 = 1'b1;
    repeat (3) edge_();
    nrst2 = 1'b0;
    #1;
    checks++;
    if ({dout2, rise2, fall2, gc2} !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid: dout=%b rise=%b fall=%b gc=%0d, want all 0", dout2, rise2, fall2, gc2);
    end
    #2;
    nrst2 = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      edge_();
      checks++;
      if (dout2 !== (i >= 4) || rise2 !== (i == 4)) begin
        errors++;
        $display("FAIL reset_requal edge %0d: dout=%b rise=%b, want dout=%b rise=%b", i, dout2, rise2, i >= 4, i == 4);
      end
    end
  endtask
  task automatic test_hold1();
    int pat[6] = '{1, 1, 0, 0, 0, 0};
    din3 = 1'b1;
    edge_();
    din3 = 1'b0;
    edge_();
    checks++;
    if (gc3 !== 8'd1 || dout3 !== 1'b0 || rise3 !== 1'b0) begin
      errors++;
      $display("FAIL hold1_glitch: gc=%0d dout=%b rise=%b, want gc=1 dout=0 rise=0", gc3, dout3, rise3);
    end
    for (int i = 0; i < 6; i++) begin
      din3 = pat[i][0];
      edge_();
      checks++;
      if (dout3 !== (i == 1 || i == 2) || rise3 !== (i == 1) || fall3 !== (i == 3)) begin
        errors++;
        $display("FAIL hold1_pulse edge %0d: dout=%b rise=%b fall=%b, want dout=%b rise=%b fall=%b", i, dout3, rise3, fall3, i == 1 || i == 2, i == 1, i == 3);
      end
    end
  endtask
  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_prescale();
    test_saturation();
    test_reset_mid();
    test_hold1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
